// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StHalted
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h00000000;
  localparam int unsigned WORD_BYTES           = 4;

  function automatic logic [31:0] word_align(logic [31:0] addr);
    return addr & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Avalon-style read port between the fetch unit (master) and instruction memory (slave).
interface instruction_fetch_if;

  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  modport master (
    output mem_address,
    output mem_read,
    output mem_byteenable,
    input  mem_waitrequest,
    input  mem_readdata
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_byteenable,
    output mem_waitrequest,
    output mem_readdata
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads one word at a time, holds it on a valid/ready
// output and applies branch targets after the delay slot. Stops on reaching HALT_ADDR.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_if.master        mem,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr_data,
  output logic [31:0]                instr_pc,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       active
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_data_q, instr_data_d;
  logic [31:0]  instr_pc_q, instr_pc_d;

  logic [31:0]  redirect_target;
  logic [31:0]  next_pc;
  logic         consume;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_pc_d       = pend_pc_q;
    pend_valid_d    = pend_valid_q;
    instr_valid_d   = instr_valid_q;
    instr_data_d    = instr_data_q;
    instr_pc_d      = instr_pc_q;
    next_pc         = pc_q + 32'(WORD_BYTES);
    redirect_target = word_align(redirect_pc);
    consume         = (state_q == StHold) && instr_valid_q && instr_ready;

    // The held or in-flight word is the delay slot; the target waits in pend_pc.
    if (redirect_valid && (state_q != StHalted)) begin
      pend_pc_d    = redirect_target;
      pend_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (!mem.mem_waitrequest) begin
          instr_data_d  = mem.mem_readdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = StHold;
        end
      end
      StHold: begin
        if (consume) begin
          if (redirect_valid) begin
            next_pc = redirect_target;
          end else if (pend_valid_q) begin
            next_pc = pend_pc_q;
          end
          pend_valid_d  = 1'b0;
          instr_valid_d = 1'b0;
          pc_d          = next_pc;
          state_d       = (next_pc == HALT_ADDR) ? StHalted : StFetch;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_VECTOR;
      pend_pc_q     <= '0;
      pend_valid_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_valid_q  <= pend_valid_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign mem.mem_address    = pc_q;
  assign mem.mem_read       = (state_q == StFetch);
  assign mem.mem_byteenable = 4'hF;

  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign active      = (state_q != StHalted);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a random run, all
// checked against a transaction-level model of fetch order and delay-slot redirects.
module tb_instruction_fetch;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] HA = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        active;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_if mem_bus ();

  instruction_fetch #(
    .RESET_VECTOR(RV),
    .HALT_ADDR   (HA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_bus.master),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .active        (active)
  );

  // Reference model: what the fetch unit is doing, expressed as flags and a program order.
  bit          m_idle, m_fetching, m_holding, m_halted, m_pend_v;
  logic [31:0] m_pc, m_pend_pc, m_data, m_ipc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idle     = 1'b1;
    m_fetching = 1'b0;
    m_holding  = 1'b0;
    m_halted   = 1'b0;
    m_pend_v   = 1'b0;
    m_pc       = RV;
    m_pend_pc  = '0;
    m_data     = '0;
    m_ipc      = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_read"}, 32'(mem_bus.mem_read), 32'd0);
    chk({tag, "_mem_address"}, mem_bus.mem_address, RV);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr_data"}, instr_data, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd1);
  endtask

  task automatic check_outputs();
    chk("mem_read", 32'(mem_bus.mem_read), 32'(m_fetching));
    if (m_fetching) chk("mem_address", mem_bus.mem_address, m_pc);
    if (m_fetching) chk("mem_byteenable", 32'(mem_bus.mem_byteenable), 32'hF);
    chk("instr_valid", 32'(instr_valid), 32'(m_holding));
    if (m_holding) begin
      chk("instr_data", instr_data, m_data);
      chk("instr_pc", instr_pc, m_ipc);
    end
    chk("active", 32'(active), 32'(!m_halted));
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          redir;
    bit          used;
    tgt   = redirect_pc & 32'hFFFF_FFFC;
    redir = redirect_valid && !m_halted;
    used  = 1'b0;
    if (m_idle) begin
      m_idle     = 1'b0;
      m_fetching = 1'b1;
    end else if (m_fetching && !mem_bus.mem_waitrequest) begin
      m_fetching = 1'b0;
      m_holding  = 1'b1;
      m_data     = mem_bus.mem_readdata;
      m_ipc      = m_pc;
    end else if (m_holding && instr_ready) begin
      if (redir) begin
        m_pc = tgt;
        used = 1'b1;
      end else if (m_pend_v) begin
        m_pc = m_pend_pc;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_pend_v  = 1'b0;
      m_holding = 1'b0;
      if (m_pc == HA) m_halted = 1'b1;
      else m_fetching = 1'b1;
    end
    if (redir && !used) begin
      m_pend_v  = 1'b1;
      m_pend_pc = tgt;
    end
  endtask

  // One clock: drive inputs, check current outputs, advance model, cross the edge.
  task automatic cyc(input bit w, input bit rdy, input bit rv, input logic [31:0] rp);
    mem_bus.mem_waitrequest = w;
    mem_bus.mem_readdata    = $urandom;
    instr_ready             = rdy;
    redirect_valid          = rv;
    redirect_pc             = rp;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n                   = 1'b0;
    mem_bus.mem_waitrequest = 1'b0;
    mem_bus.mem_readdata    = '0;
    instr_ready             = 1'b0;
    redirect_valid          = 1'b0;
    redirect_pc             = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values(tag);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit done;

    // 1: back-to-back fetches at full rate
    do_reset("reset");
    repeat (8) cyc(1'b0, 1'b1, 1'b0, '0);

    // 2: three stall cycles on the first fetch
    do_reset("reset2");
    cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, '0);

    // 3: core refuses the word for five cycles
    repeat (5) cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, '0);

    // 4: redirect during the fetch at 0xBFC00008 (that word is the delay slot)
    do_reset("reset4");
    done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (!done && m_fetching && m_pc == 32'hBFC00008) begin
        done = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 32'hBFC00100);
      end else begin
        cyc(1'b0, 1'b1, 1'b0, '0);
      end
    end

    // 5: redirect to 0x3 (aligned to HALT_ADDR); halt after its delay slot
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!done && m_fetching) begin
        done = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 32'h00000003);
      end else begin
        cyc(1'b0, 1'b1, 1'b0, '0);
      end
    end
    chk("halted_active", 32'(active), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 32'hBFC00200 + 32'(i * 4));

    // 6: asynchronous reset while a fetch is stalled
    do_reset("reset6");
    repeat (3) cyc(1'b1, 1'b1, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (6) cyc(1'b0, 1'b1, 1'b0, '0);

    // PC wrap: fetch at 0xFFFFFFFC, pc+4 wraps to HALT_ADDR
    do_reset("reset_wrap");
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFFFFFE);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_active", 32'(active), 32'd0);

    // Random stalls, back-pressure and redirects
    do_reset("reset_rand");
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
          32'hBFC00000 | ($urandom & 32'h000F_FFFF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
